// File: rtl/mem_arbiter.sv
// Two-way arbiter sharing one RAM port between instruction fetch and data access, with data given priority.
// Optional starvation guard for instruction fetch, enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter #(
    parameter int WORD_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    output logic [WORD_W-1:0] iload,
    output logic              iwait,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic [WORD_W-1:0] dload,
    output logic              dwait,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        IGNT = 2'b01,
        DGNT = 2'b10
    } state_t;

    localparam logic [1:0] RAM_ACCESS = 2'b10;
    localparam logic [1:0] RAM_ERROR  = 2'b11;

    state_t state_reg, state_next;
    logic   d_req;
    logic   force_i;

    assign d_req = dREN | dWEN;

    // RAM read data is shared; each side qualifies it with its own wait.
    assign iload = ramload;
    assign dload = ramload;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        iwait      = iREN;
        dwait      = d_req;
        case (state_reg)
            IDLE: begin
                if (force_i) begin
                    state_next = IGNT;
                end else if (d_req) begin
                    state_next = DGNT;
                end else if (iREN) begin
                    state_next = IGNT;
                end
            end
            IGNT: begin
                // Enables follow the live request so a dropped request releases RAM at once.
                ramREN  = iREN;
                ramaddr = iaddr;
                iwait   = 1'b1;
                if (!iREN) begin
                    state_next = IDLE;
                end else if (ramstate == RAM_ACCESS) begin
                    iwait      = 1'b0;
                    state_next = IDLE;
                end else if (ramstate == RAM_ERROR) begin
                    state_next = IDLE;
                end
            end
            DGNT: begin
                ramREN   = dREN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dwait    = 1'b1;
                if (!d_req) begin
                    state_next = IDLE;
                end else if (ramstate == RAM_ACCESS) begin
                    dwait      = 1'b0;
                    state_next = IDLE;
                end else if (ramstate == RAM_ERROR) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt_reg, starve_cnt_next;
    logic             i_done, d_done;

    assign i_done  = (state_reg == IGNT) && iREN && (ramstate == RAM_ACCESS);
    assign d_done  = (state_reg == DGNT) && d_req && (ramstate == RAM_ACCESS);
    assign force_i = (state_reg == IDLE) && iREN && (starve_cnt_reg == STARVE_MAX);

    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (i_done) begin
            starve_cnt_next = '0;
        end else if (d_done && iREN) begin
            if (starve_cnt_reg != STARVE_MAX) begin
                starve_cnt_next = starve_cnt_reg + 1'b1;
            end
        end else if ((state_reg == IDLE) && !iREN) begin
            starve_cnt_next = '0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            starve_cnt_reg <= '0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
        end
    end
`else
    // Strict data priority: instruction fetch can be starved indefinitely.
    assign force_i = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: inputs driven on the falling edge, outputs checked 1ns later.
module tb_mem_arbiter;

    localparam int W = 32;
    localparam logic [1:0] FREE   = 2'b00;
    localparam logic [1:0] BUSY   = 2'b01;
    localparam logic [1:0] ACCESS = 2'b10;
    localparam logic [1:0] ERROR  = 2'b11;

    logic         CLK = 1'b0;
    logic         nRST;
    logic         iREN, dREN, dWEN;
    logic [W-1:0] iaddr, daddr, dstore, ramload;
    logic [1:0]   ramstate;
    logic [W-1:0] iload, dload, ramaddr, ramstore;
    logic         iwait, dwait, ramREN, ramWEN;

    int tests = 0;
    int fails = 0;

    mem_arbiter #(.WORD_W(W), .STARVE_LIMIT(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic clear_inputs();
        iREN = 0; dREN = 0; dWEN = 0;
        iaddr = '0; daddr = '0; dstore = '0;
        ramstate = FREE;
    endtask

    task automatic test_reset();
        nRST = 0; iREN = 1; dREN = 0; dWEN = 1;
        iaddr = 32'h10; daddr = 32'h20; dstore = 32'h30;
        ramload = 32'h12345678; ramstate = ACCESS;
        @(negedge CLK); #1;
        tests++; if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin fails++; $display("FAIL reset_en: got ren=%b wen=%b want 0 0", ramREN, ramWEN); end
        tests++; if (ramaddr !== 32'h0 || ramstore !== 32'h0) begin fails++; $display("FAIL reset_bus: got addr=%h store=%h want 0 0", ramaddr, ramstore); end
        tests++; if (iwait !== 1'b1 || dwait !== 1'b1) begin fails++; $display("FAIL reset_wait: got iwait=%b dwait=%b want 1 1", iwait, dwait); end
        tests++; if (iload !== 32'h12345678 || dload !== 32'h12345678) begin fails++; $display("FAIL reset_load: got iload=%h dload=%h want 12345678", iload, dload); end
        clear_inputs();
        #1;
        tests++; if (iwait !== 1'b0 || dwait !== 1'b0) begin fails++; $display("FAIL reset_wait_idle: got iwait=%b dwait=%b want 0 0", iwait, dwait); end
        @(negedge CLK); nRST = 1;
        $display("[TB] test_reset done");
    endtask

    task automatic test_ifetch();
        @(negedge CLK);
        iREN = 1; iaddr = 32'h40; ramstate = ACCESS; ramload = 32'h8C010004;
        #1;
        tests++; if (ramREN !== 1'b0 || iwait !== 1'b1) begin fails++; $display("FAIL ifetch_c0: got ren=%b iwait=%b want 0 1", ramREN, iwait); end
        @(negedge CLK); #1;
        tests++; if (ramREN !== 1'b1 || ramaddr !== 32'h40) begin fails++; $display("FAIL ifetch_c1_ram: got ren=%b addr=%h want 1 40", ramREN, ramaddr); end
        tests++; if (iwait !== 1'b0 || iload !== 32'h8C010004) begin fails++; $display("FAIL ifetch_c1_done: got iwait=%b iload=%h want 0 8c010004", iwait, iload); end
        // Second fetch from the same side must be separated by an idle cycle
        @(negedge CLK); #1;
        tests++; if (ramREN !== 1'b0 || iwait !== 1'b1) begin fails++; $display("FAIL b2b_idle: got ren=%b iwait=%b want 0 1", ramREN, iwait); end
        @(negedge CLK); #1;
        tests++; if (ramREN !== 1'b1 || iwait !== 1'b0) begin fails++; $display("FAIL b2b_done: got ren=%b iwait=%b want 1 0", ramREN, iwait); end
        @(negedge CLK); clear_inputs();
        $display("[TB] test_ifetch done");
    endtask

    task automatic test_dwrite_busy();
        @(negedge CLK);
        dWEN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF; ramstate = BUSY;
        #1;
        tests++; if (ramWEN !== 1'b0 || dwait !== 1'b1) begin fails++; $display("FAIL dwr_c1: got wen=%b dwait=%b want 0 1", ramWEN, dwait); end
        for (int k = 2; k <= 5; k++) begin
            @(negedge CLK);
            ramstate = (k == 5) ? ACCESS : BUSY;
            #1;
            tests++;
            if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h100 || ramstore !== 32'hDEADBEEF
                || dwait !== ((k == 5) ? 1'b0 : 1'b1)) begin
                fails++;
                $display("FAIL dwr_c%0d: got wen=%b ren=%b addr=%h store=%h dwait=%b want 1 0 100 deadbeef %b",
                         k, ramWEN, ramREN, ramaddr, ramstore, dwait, (k == 5) ? 1'b0 : 1'b1);
            end
        end
        @(negedge CLK); clear_inputs(); #1;
        tests++; if (ramWEN !== 1'b0) begin fails++; $display("FAIL dwr_after: got wen=%b want 0", ramWEN); end
        $display("[TB] test_dwrite_busy done");
    endtask

    task automatic test_simultaneous();
        @(negedge CLK);
        iREN = 1; dREN = 1; iaddr = 32'h80; daddr = 32'h200; ramstate = BUSY; ramload = 32'h11;
        #1;
        tests++; if (iwait !== 1'b1 || dwait !== 1'b1) begin fails++; $display("FAIL sim_c0: got iwait=%b dwait=%b want 1 1", iwait, dwait); end
        @(negedge CLK); #1;
        tests++; if (ramREN !== 1'b1 || ramaddr !== 32'h200 || iwait !== 1'b1) begin fails++; $display("FAIL sim_dgnt: got ren=%b addr=%h iwait=%b want 1 200 1", ramREN, ramaddr, iwait); end
        @(negedge CLK); ramstate = ACCESS; #1;
        tests++; if (dwait !== 1'b0 || iwait !== 1'b1 || dload !== 32'h11) begin fails++; $display("FAIL sim_ddone: got dwait=%b iwait=%b dload=%h want 0 1 11", dwait, iwait, dload); end
        @(negedge CLK); dREN = 0; ramstate = BUSY; #1;
        tests++; if (ramREN !== 1'b0 || iwait !== 1'b1) begin fails++; $display("FAIL sim_idle: got ren=%b iwait=%b want 0 1", ramREN, iwait); end
        @(negedge CLK); #1;
        tests++; if (ramREN !== 1'b1 || ramaddr !== 32'h80 || iwait !== 1'b1) begin fails++; $display("FAIL sim_ignt: got ren=%b addr=%h iwait=%b want 1 80 1", ramREN, ramaddr, iwait); end
        @(negedge CLK); ramstate = ACCESS; #1;
        tests++; if (iwait !== 1'b0) begin fails++; $display("FAIL sim_idone: got iwait=%b want 0", iwait); end
        @(negedge CLK); clear_inputs();
        $display("[TB] test_simultaneous done");
    endtask

    task automatic test_error_retry();
        @(negedge CLK);
        iREN = 1; iaddr = 32'h44; ramstate = ERROR;
        @(negedge CLK); #1;
        tests++; if (ramREN !== 1'b1 || iwait !== 1'b1) begin fails++; $display("FAIL err_ignt: got ren=%b iwait=%b want 1 1", ramREN, iwait); end
        @(negedge CLK); #1;
        tests++; if (ramREN !== 1'b0 || iwait !== 1'b1) begin fails++; $display("FAIL err_idle: got ren=%b iwait=%b want 0 1", ramREN, iwait); end
        @(negedge CLK); ramstate = ACCESS; #1;
        tests++; if (ramREN !== 1'b1 || ramaddr !== 32'h44 || iwait !== 1'b0) begin fails++; $display("FAIL err_retry: got ren=%b addr=%h iwait=%b want 1 44 0", ramREN, ramaddr, iwait); end
        @(negedge CLK); clear_inputs();
        $display("[TB] test_error_retry done");
    endtask

    task automatic test_drop();
        @(negedge CLK);
        iREN = 1; iaddr = 32'h48; ramstate = BUSY;
        @(negedge CLK); #1;
        tests++; if (ramREN !== 1'b1) begin fails++; $display("FAIL drop_gnt: got ren=%b want 1", ramREN); end
        @(negedge CLK); iREN = 0; #1;
        tests++; if (ramREN !== 1'b0) begin fails++; $display("FAIL drop_same: got ren=%b want 0", ramREN); end
        @(negedge CLK); iREN = 1; #1;
        tests++; if (ramREN !== 1'b0) begin fails++; $display("FAIL drop_idle: got ren=%b want 0", ramREN); end
        @(negedge CLK); ramstate = ACCESS; #1;
        tests++; if (ramREN !== 1'b1 || iwait !== 1'b0) begin fails++; $display("FAIL drop_reissue: got ren=%b iwait=%b want 1 0", ramREN, iwait); end
        @(negedge CLK); clear_inputs();
        $display("[TB] test_drop done");
    endtask

    task automatic test_reset_mid_dgnt();
        @(negedge CLK);
        dREN = 1; daddr = 32'h300; ramstate = BUSY;
        @(negedge CLK); #1;
        tests++; if (ramREN !== 1'b1) begin fails++; $display("FAIL rstmid_gnt: got ren=%b want 1", ramREN); end
        #2; nRST = 0; #1;
        tests++; if (ramREN !== 1'b0 || ramaddr !== 32'h0 || dwait !== 1'b1) begin fails++; $display("FAIL rstmid_async: got ren=%b addr=%h dwait=%b want 0 0 1", ramREN, ramaddr, dwait); end
        @(negedge CLK); nRST = 1; #1;
        tests++; if (ramREN !== 1'b0) begin fails++; $display("FAIL rstmid_idle: got ren=%b want 0", ramREN); end
        @(negedge CLK); ramstate = ACCESS; #1;
        tests++; if (ramREN !== 1'b1 || dwait !== 1'b0) begin fails++; $display("FAIL rstmid_reissue: got ren=%b dwait=%b want 1 0", ramREN, dwait); end
        @(negedge CLK); clear_inputs();
        $display("[TB] test_reset_mid_dgnt done");
    endtask

    task automatic test_starve();
        string seq;
        string exp_seq;
        int    n_i;
        seq = ""; n_i = 0;
`ifdef MEM_ARB_STARVE_GUARD_EN
        exp_seq = "DDDDIDDDDI";
`else
        exp_seq = "DDDDDDDDDD";
`endif
        @(negedge CLK);
        dREN = 1; iREN = 1; daddr = 32'h500; iaddr = 32'h600; ramstate = ACCESS;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) @(negedge CLK);
            #1;
            if (dwait === 1'b0) seq = {seq, "D"};
            if (iwait === 1'b0) begin seq = {seq, "I"}; n_i++; end
        end
        tests++; if (seq != exp_seq) begin fails++; $display("FAIL starve_seq: got %s want %s", seq, exp_seq); end
`ifndef MEM_ARB_STARVE_GUARD_EN
        tests++; if (n_i != 0) begin fails++; $display("FAIL starve_noi: got %0d I completions want 0", n_i); end
`else
        tests++; if (n_i != 2) begin fails++; $display("FAIL starve_i: got %0d I completions want 2", n_i); end
`endif
        @(negedge CLK); clear_inputs();
        $display("[TB] test_starve done: completions %s", seq);
    endtask

    initial begin
        ramload = '0;
        clear_inputs();
        test_reset();
        test_ifetch();
        test_dwrite_busy();
        test_simultaneous();
        test_error_retry();
        test_drop();
        test_reset_mid_dgnt();
        test_starve();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
